// File: rtl/pi_leibniz_seq.sv
// Sequential Leibniz-series pi accumulator: each pair adds floor(M/k) - floor(M/(k+2))
// using one shared restoring divider that resolves one quotient bit per cycle.
module pi_leibniz_seq #(
    parameter int unsigned FRAC_HEX = 15,
    parameter int unsigned W        = 64,
    parameter int unsigned CW       = 16
) (
    input  logic          clk_2,
    input  logic          reset_n,
    input  logic          start,
    input  logic [CW-1:0] max_pairs,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  pi_out,
    output logic [CW-1:0] pairs_done
);

    localparam int unsigned CNTW   = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned M_SHFT = 4 * FRAC_HEX + 2;
    localparam logic [W-1:0] M_CONST = W'(1) << M_SHFT;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DIV_POS = 3'd1,
        DIV_NEG = 3'd2,
        ACC     = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t state, state_nx;

    logic [W-1:0]    k;
    logic [W-1:0]    dvs;
    logic [W-1:0]    rem;
    logic [W-1:0]    dvd;
    logic [W-1:0]    q_pos;
    logic [CNTW-1:0] bit_cnt;
    logic [CW-1:0]   max_lat;

    logic [W:0]      rem_sh;
    logic [W:0]      trial;
    logic            ge;
    logic [W-1:0]    rem_nx;
    logic [W-1:0]    dvd_nx;
    logic            last_bit;
    logic [W-1:0]    diff;
    logic [CW-1:0]   pairs_inc;
    logic            busy_nx;
    logic            done_nx;

    // One restoring-division step; dvd shifts the dividend out and the quotient in.
    always_comb begin
        rem_sh   = {rem, dvd[W-1]};
        trial    = rem_sh - {1'b0, dvs};
        ge       = ~trial[W];
        rem_nx   = ge ? trial[W-1:0] : rem_sh[W-1:0];
        dvd_nx   = {dvd[W-2:0], ge};
        last_bit = (bit_cnt == CNTW'(W - 1));
        diff     = q_pos - dvd;
        pairs_inc = (pairs_done == '1) ? pairs_done : pairs_done + CW'(1);
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;
        case (state)
            IDLE, DONE: if (start) state_nx = (max_pairs == '0) ? DONE : DIV_POS;
            DIV_POS:    if (last_bit) state_nx = DIV_NEG;
            DIV_NEG:    if (last_bit) state_nx = ACC;
            ACC:        state_nx = ((pairs_inc == max_lat) || (diff == '0)) ? DONE : DIV_POS;
            default:    state_nx = IDLE;
        endcase
        busy_nx = (state_nx == DIV_POS) || (state_nx == DIV_NEG) || (state_nx == ACC);
        done_nx = (state_nx == DONE);
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_nx;
            done <= done_nx;
        end
    end

    // Datapath: divider sequencing, pair accumulation and counters.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            pi_out     <= '0;
            pairs_done <= '0;
            k          <= W'(1);
            dvs        <= '0;
            rem        <= '0;
            dvd        <= '0;
            q_pos      <= '0;
            bit_cnt    <= '0;
            max_lat    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        pi_out     <= '0;
                        pairs_done <= '0;
                        k          <= W'(1);
                        max_lat    <= max_pairs;
                        dvs        <= W'(1);
                        rem        <= '0;
                        dvd        <= M_CONST;
                        bit_cnt    <= '0;
                    end
                end
                DIV_POS: begin
                    rem     <= rem_nx;
                    dvd     <= dvd_nx;
                    bit_cnt <= bit_cnt + CNTW'(1);
                    if (last_bit) begin
                        q_pos   <= dvd_nx;
                        rem     <= '0;
                        dvd     <= M_CONST;
                        dvs     <= k + W'(2);
                        bit_cnt <= '0;
                    end
                end
                DIV_NEG: begin
                    rem     <= rem_nx;
                    dvd     <= dvd_nx;
                    bit_cnt <= last_bit ? '0 : bit_cnt + CNTW'(1);
                end
                ACC: begin
                    // dvd holds floor(M/(k+2)) here; k stays odd so no divisor is ever zero.
                    pi_out     <= pi_out + diff;
                    pairs_done <= pairs_inc;
                    k          <= k + W'(4);
                    dvs        <= k + W'(4);
                    rem        <= '0;
                    dvd        <= M_CONST;
                    bit_cnt    <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pi_leibniz_seq.sv
// Directed bench for pi_leibniz_seq at FRAC_HEX=1, W=16 (M=64), hand-computed pair sums.
module tb_pi_leibniz_seq;

    logic        clk_2;
    logic        reset_n;
    logic        start;
    logic [15:0] max_pairs;
    logic        busy;
    logic        done;
    logic [15:0] pi_out;
    logic [15:0] pairs_done;

    int checks   = 0;
    int failures = 0;
    int n;
    int busy_n;

    pi_leibniz_seq #(.FRAC_HEX(1), .W(16), .CW(16)) dut (
        .clk_2      (clk_2),
        .reset_n    (reset_n),
        .start      (start),
        .max_pairs  (max_pairs),
        .busy       (busy),
        .done       (done),
        .pi_out     (pi_out),
        .pairs_done (pairs_done)
    );

    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; pulses start, counts edges to done and cycles with busy high.
    // A start re-pulse with max_pairs=1 is injected after edge rp (rp<0 disables it).
    task automatic run(input string tag, input logic [15:0] mp, input int rp,
                       input int exp_edges, input logic [15:0] exp_pi, input logic [15:0] exp_pairs);
        start     = 1'b1;
        max_pairs = mp;
        @(posedge clk_2);
        #1 start = 1'b0;
        n      = 0;
        busy_n = 0;
        @(negedge clk_2);
        while (!done && n < 2000) begin
            if (busy) busy_n++;
            @(posedge clk_2);
            n++;
            @(negedge clk_2);
            start = (n == rp);
            if (n == rp) max_pairs = 16'd1;
        end
        start = 1'b0;
        chk({tag, "_edges"}, 64'(n), 64'(exp_edges));
        chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_edges));
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_busy_end"}, 64'(busy), 64'd0);
        chk({tag, "_pi"}, 64'(pi_out), 64'(exp_pi));
        chk({tag, "_pairs"}, 64'(pairs_done), 64'(exp_pairs));
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        max_pairs = '0;
        repeat (3) @(posedge clk_2);
        @(negedge clk_2);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_pi", 64'(pi_out), 64'd0);
        chk("rst_pairs", 64'(pairs_done), 64'd0);

        // Start presented together with reset release: accepted on the first edge.
        reset_n = 1'b1;
        run("zero", 16'd0, -1, 0, 16'h0000, 16'd0);

        // 64-21 + 12-9 = 46
        run("two", 16'd2, -1, 66, 16'h002E, 16'd2);
        repeat (5) @(negedge clk_2);
        chk("hold_done", 64'(done), 64'd1);
        chk("hold_pi", 64'(pi_out), 64'h2E);
        chk("hold_busy", 64'(busy), 64'd0);

        // Fourth pair 64/13 - 64/15 = 0 terminates early.
        run("stop0", 16'd100, -1, 132, 16'h0030, 16'd4);
        run("one", 16'd1, -1, 33, 16'h002B, 16'd1);
        run("ignore", 16'd2, 20, 66, 16'h002E, 16'd2);
        run("three", 16'd3, -1, 99, 16'h0030, 16'd3);

        // Abort during second pair's DIV_POS (edges 34..49).
        start     = 1'b1;
        max_pairs = 16'd2;
        @(posedge clk_2);
        #1 start = 1'b0;
        repeat (40) @(posedge clk_2);
        @(negedge clk_2);
        chk("mid_pi", 64'(pi_out), 64'h2B);
        chk("mid_pairs", 64'(pairs_done), 64'd1);
        chk("mid_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_pi", 64'(pi_out), 64'd0);
        chk("abort_pairs", 64'(pairs_done), 64'd0);
        repeat (2) @(negedge clk_2);
        reset_n = 1'b1;
        run("restart", 16'd2, -1, 66, 16'h002E, 16'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
